// File: rtl/pattern_seq_ctrl.sv
// rtl/pattern_seq_ctrl.sv - table-driven burst sequencer for the pattern/DAC generator
module pattern_seq_ctrl #(
    parameter int DEPTH     = 4,
    parameter int IDX_W     = 2,
    parameter int LAUNCH_TO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [55:0]      wr_data,
    input  logic [IDX_W:0]   num_entries,
    input  logic [7:0]       loop_num,
    input  logic             start_req,
    input  logic             stop_req,
    input  logic             gen_busy,
    output logic             gen_pwm_en,
    output logic [7:0]       gen_pat,
    output logic [7:0]       gen_duty_num,
    output logic [15:0]      gen_pulse_dessert,
    output logic [7:0]       gen_pulse_num,
    output logic             seq_busy,
    output logic             seq_done,
    output logic             seq_err,
    output logic [IDX_W-1:0] cur_idx,
    output logic [7:0]       loop_cnt
);
    localparam int TO_W = $clog2(LAUNCH_TO + 1);
    localparam logic [IDX_W:0] MAX_ENT = (IDX_W + 1)'(DEPTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LAUNCH_TO);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LAUNCH, S_DWELL, S_DRAIN, S_NEXT} state_t;

    state_t           state_q, state_d;
    logic [55:0]      tbl_q [DEPTH];
    logic             pwm_q, pwm_d;
    logic [7:0]       pat_q, pat_d, duty_q, duty_d, pnum_q, pnum_d;
    logic [15:0]      dessert_q, dessert_d;
    logic [15:0]      dwell_cnt_q, dwell_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d, stop_q, stop_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       loops_q, loops_d, loop_num_q, loop_num_d;
    logic [IDX_W:0]   n_ent_q, n_ent_d;
    logic [55:0]      entry;
    logic             timeout;

    assign entry = tbl_q[idx_q];

    // The table has no reset; it is only writable while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == S_IDLE) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        duty_d      = duty_q;
        dessert_d   = dessert_q;
        pnum_d      = pnum_q;
        dwell_cnt_d = dwell_cnt_q;
        to_cnt_d    = to_cnt_q;
        err_d       = err_q;
        stop_d      = stop_q;
        idx_d       = idx_q;
        loops_d     = loops_q;
        loop_num_d  = loop_num_q;
        n_ent_d     = n_ent_q;
        timeout     = 1'b0;

        if (state_q != S_IDLE && stop_req) begin
            stop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_req && num_entries != '0 && num_entries <= MAX_ENT) begin
                    idx_d      = '0;
                    loops_d    = '0;
                    err_d      = 1'b0;
                    stop_d     = 1'b0;
                    n_ent_d    = num_entries;
                    loop_num_d = loop_num;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                pat_d       = entry[7:0];
                duty_d      = entry[15:8];
                dessert_d   = entry[31:16];
                pnum_d      = entry[39:32];
                dwell_cnt_d = (entry[55:40] == 16'd0) ? 16'd1 : entry[55:40];
                to_cnt_d    = '0;
                state_d     = (entry[15:8] == 8'd0 || entry[7:0] == 8'd0) ? S_NEXT : S_LAUNCH;
            end
            S_LAUNCH: begin
                if (gen_busy) begin
                    state_d = (pnum_q != 8'd0) ? S_DRAIN : S_DWELL;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_DWELL: begin
                if (stop_q || stop_req || dwell_cnt_q == 16'd1) begin
                    state_d = S_DRAIN;
                end else begin
                    dwell_cnt_d = dwell_cnt_q - 16'd1;
                end
            end
            S_DRAIN: begin
                if (!gen_busy) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if ({1'b0, idx_q} == n_ent_q - (IDX_W + 1)'(1)) begin
                    idx_d   = '0;
                    loops_d = (loops_q == 8'hFF) ? loops_q : loops_q + 8'd1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (stop_q || stop_req || (loop_num_q != 8'd0 && loops_d == loop_num_q)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // pwm_en is high only while both this and the next state drive the generator,
        // so it is always low on the edge that reloads the config outputs.
        pwm_d  = (state_q == S_LAUNCH || state_q == S_DWELL) &&
                 (state_d == S_LAUNCH || state_d == S_DWELL);
        busy_d = (state_q != S_IDLE) && (state_d != S_IDLE);
        done_d = (state_q != S_IDLE) && (state_d == S_IDLE) && !timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pwm_q       <= 1'b0;
            pat_q       <= '0;
            duty_q      <= '0;
            dessert_q   <= '0;
            pnum_q      <= '0;
            dwell_cnt_q <= '0;
            to_cnt_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            stop_q      <= 1'b0;
            idx_q       <= '0;
            loops_q     <= '0;
            loop_num_q  <= '0;
            n_ent_q     <= '0;
        end else begin
            state_q     <= state_d;
            pwm_q       <= pwm_d;
            pat_q       <= pat_d;
            duty_q      <= duty_d;
            dessert_q   <= dessert_d;
            pnum_q      <= pnum_d;
            dwell_cnt_q <= dwell_cnt_d;
            to_cnt_q    <= to_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            stop_q      <= stop_d;
            idx_q       <= idx_d;
            loops_q     <= loops_d;
            loop_num_q  <= loop_num_d;
            n_ent_q     <= n_ent_d;
        end
    end

    assign gen_pwm_en        = pwm_q;
    assign gen_pat           = pat_q;
    assign gen_duty_num      = duty_q;
    assign gen_pulse_dessert = dessert_q;
    assign gen_pulse_num     = pnum_q;
    assign seq_busy          = busy_q;
    assign seq_done          = done_q;
    assign seq_err           = err_q;
    assign cur_idx           = idx_q;
    assign loop_cnt          = loops_q;
endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// tb/tb_pattern_seq_ctrl.sv - directed self-checking bench for pattern_seq_ctrl
module tb_pattern_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [55:0] wr_data;
    logic [2:0]  num_entries;
    logic [7:0]  loop_num;
    logic        start_req, stop_req, gen_busy;
    logic        gen_pwm_en;
    logic [7:0]  gen_pat, gen_duty_num, gen_pulse_num;
    logic [15:0] gen_pulse_dessert;
    logic        seq_busy, seq_done, seq_err;
    logic [1:0]  cur_idx;
    logic [7:0]  loop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int hicnt;
    logic [39:0] cfg_prev = '0;

    pattern_seq_ctrl #(.DEPTH(4), .IDX_W(2), .LAUNCH_TO(15)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_entries(num_entries), .loop_num(loop_num), .start_req(start_req),
        .stop_req(stop_req), .gen_busy(gen_busy), .gen_pwm_en(gen_pwm_en),
        .gen_pat(gen_pat), .gen_duty_num(gen_duty_num),
        .gen_pulse_dessert(gen_pulse_dessert), .gen_pulse_num(gen_pulse_num),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err),
        .cur_idx(cur_idx), .loop_cnt(loop_cnt)
    );

    always #5 clk = ~clk;

    // Config outputs may only change while pwm_en is low; also tally seq_done pulses.
    always @(negedge clk) begin
        if (seq_done) done_cnt++;
        if ({gen_pat, gen_duty_num, gen_pulse_dessert, gen_pulse_num} != cfg_prev) begin
            n_cmp++;
            assert (gen_pwm_en === 1'b0) else begin
                n_bad++;
                $error("FAIL order: pwm_en observed=%0b expected=0 on config change", gen_pwm_en);
            end
        end
        cfg_prev = {gen_pat, gen_duty_num, gen_pulse_dessert, gen_pulse_num};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] mk(input logic [15:0] dwell, input logic [7:0] pnum,
                                       input logic [15:0] des, input logic [7:0] duty,
                                       input logic [7:0] pat);
        return {dwell, pnum, des, duty, pat};
    endfunction

    task automatic wr(input logic [1:0] a, input logic [55:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start(input logic [2:0] n, input logic [7:0] loops);
        num_entries = n; loop_num = loops; start_req = 1'b1;
        tick();
        start_req = 1'b0;
    endtask

    // Called with pwm_en just risen; serves one finite burst and walks to the next pwm rise.
    task automatic finite_burst(input logic [1:0] idx, input int gap);
        chk("burst_pwm_hi", gen_pwm_en, 1);
        chk("burst_idx", cur_idx, idx);
        gen_busy = 1'b1;
        tick();
        chk("burst_pwm_fall", gen_pwm_en, 0);
        tick();
        tick();
        gen_busy = 1'b0;
        for (int i = 0; i < gap; i++) begin
            tick();
            chk("gap_pwm_lo", gen_pwm_en, 0);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; num_entries = '0;
        loop_num = '0; start_req = 1'b0; stop_req = 1'b0; gen_busy = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_pwm", gen_pwm_en, 0);
        chk("rst_busy", seq_busy, 0);
        chk("rst_done", seq_done, 0);
        chk("rst_err", seq_err, 0);
        chk("rst_cfg", {gen_pat, gen_duty_num, gen_pulse_dessert, gen_pulse_num}, 0);
        chk("rst_idx_loop", {cur_idx, loop_cnt}, 0);

        // Three finite entries, one pass
        for (int i = 0; i < 3; i++) wr(2'(i), mk(16'd0, 8'd2, 16'd4, 8'd2, 8'b1011));
        start(3'd3, 8'd1);
        chk("t1_busy_k", seq_busy, 0);
        tick();
        chk("t1_busy_k1", seq_busy, 1);
        chk("t1_pat", gen_pat, 8'h0B);
        chk("t1_cfg", {gen_duty_num, gen_pulse_dessert, gen_pulse_num}, 32'h02_0004_02);
        chk("t1_pwm_k1", gen_pwm_en, 0);
        tick();
        finite_burst(2'd0, 3);
        finite_burst(2'd1, 3);
        chk("t1_pwm_e2", gen_pwm_en, 1);
        chk("t1_idx2", cur_idx, 2);
        gen_busy = 1'b1;
        tick();
        chk("t1_pwm_fall2", gen_pwm_en, 0);
        tick();
        gen_busy = 1'b0;
        tick();
        chk("t1_done_early", seq_done, 0);
        tick();
        chk("t1_done", seq_done, 1);
        chk("t1_busy_end", seq_busy, 0);
        chk("t1_loop", loop_cnt, 1);
        chk("t1_idx_end", cur_idx, 0);
        tick();
        chk("t1_done_cnt", done_cnt, 1);

        // Infinite entry with dwell of 100
        wr(2'd0, mk(16'd100, 8'd0, 16'd9, 8'd1, 8'h01));
        start(3'd1, 8'd1);
        tick(); tick();
        chk("t2_pwm_hi", gen_pwm_en, 1);
        gen_busy = 1'b1;
        tick();
        hicnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (!gen_pwm_en) break;
            hicnt++;
            tick();
        end
        chk("t2_dwell_len", hicnt, 100);
        tick();
        chk("t2_drain_busy", seq_busy, 1);
        gen_busy = 1'b0;
        tick(); tick();
        chk("t2_done", seq_done, 1);
        tick();
        chk("t2_done_cnt", done_cnt, 2);

        // Skip: entry 1 has duty_num 0
        wr(2'd0, mk(16'd0, 8'd1, 16'd3, 8'd1, 8'h03));
        wr(2'd1, mk(16'd0, 8'd1, 16'd3, 8'd0, 8'h03));
        wr(2'd2, mk(16'd0, 8'd1, 16'd7, 8'd3, 8'h0C));
        start(3'd3, 8'd1);
        tick(); tick();
        finite_burst(2'd0, 5);
        chk("t3_pwm_e2", gen_pwm_en, 1);
        chk("t3_idx2", cur_idx, 2);
        chk("t3_pat2", gen_pat, 8'h0C);
        gen_busy = 1'b1;
        tick();
        gen_busy = 1'b0;
        tick(); tick();
        chk("t3_done", seq_done, 1);
        tick();
        chk("t3_done_cnt", done_cnt, 3);

        // Stop 50 cycles into a 1000-cycle dwell, infinite loop count
        wr(2'd0, mk(16'd1000, 8'd0, 16'd5, 8'd4, 8'h11));
        start(3'd1, 8'd0);
        tick(); tick();
        gen_busy = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) tick();
        chk("t4_pwm_before_stop", gen_pwm_en, 1);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        chk("t4_pwm_fall", gen_pwm_en, 0);
        tick(); tick();
        chk("t4_busy_drain", seq_busy, 1);
        chk("t4_no_done_yet", done_cnt, 3);
        gen_busy = 1'b0;
        tick(); tick();
        chk("t4_done", seq_done, 1);
        chk("t4_loop", loop_cnt, 1);
        tick();

        // Launch timeout with gen_busy held low
        wr(2'd0, mk(16'd0, 8'd1, 16'd5, 8'd4, 8'h22));
        start(3'd1, 8'd1);
        tick(); tick();
        hicnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!gen_pwm_en) break;
            hicnt++;
            tick();
        end
        chk("t5_to_len", hicnt, 15);
        chk("t5_err", seq_err, 1);
        chk("t5_busy", seq_busy, 0);
        tick(); tick();
        chk("t5_no_done", done_cnt, 4);

        // Restart clears seq_err; write in the start cycle is honoured
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = mk(16'd0, 8'd1, 16'd6, 8'd2, 8'h5A);
        start(3'd1, 8'd1);
        wr_en = 1'b0;
        chk("t5_err_clr", seq_err, 0);
        tick();
        chk("t6_wr_with_start", gen_pat, 8'h5A);
        wr(2'd0, mk(16'd0, 8'd1, 16'd6, 8'd2, 8'hEE));
        tick();
        chk("t6_launch_pwm", gen_pwm_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_pwm", gen_pwm_en, 0);
        chk("t6_rst_busy", seq_busy, 0);
        chk("t6_rst_cfg", {gen_pat, gen_duty_num, gen_pulse_dessert, gen_pulse_num}, 0);
        chk("t6_rst_misc", {seq_err, seq_done, cur_idx, loop_cnt}, 0);

        // Illegal num_entries are ignored
        start(3'd0, 8'd1);
        tick(); tick();
        chk("t6_n0_busy", seq_busy, 0);
        start(3'd5, 8'd1);
        tick(); tick();
        chk("t6_n5_busy", seq_busy, 0);
        chk("t6_n5_pat", gen_pat, 0);

        // Table kept the value written before the busy-time write
        start(3'd1, 8'd1);
        tick();
        chk("t6_table_kept", gen_pat, 8'h5A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_done_total", done_cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
